// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and state enumeration for the multicycle CPU control unit.
// Exception handling in control_unit is compiled in by defining CTRL_EXCEPTION_EN.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] SHIFT_HOLD = 3'b000;
    localparam logic [2:0] SHIFT_LOAD = 3'b001;
    localparam logic [2:0] SHIFT_SLL  = 3'b010;
    localparam logic [2:0] SHIFT_SRL  = 3'b011;

    localparam logic [3:0] SRCB_B    = 4'd0;
    localparam logic [3:0] SRCB_FOUR = 4'd1;
    localparam logic [3:0] SRCB_SEXT = 4'd2;
    localparam logic [3:0] SRCB_SHL2 = 4'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_EXC    = 2'd3;

    localparam logic [1:0] EXC_INVALID  = 2'd0;
    localparam logic [1:0] EXC_OVERFLOW = 2'd1;

    typedef enum logic [4:0] {
        RESET_ST,
        FETCH,
        FETCH_WAIT,
        IR_LOAD,
        DECODE,
        EX_R_ADD,
        EX_R_SUB,
        EX_R_AND,
        WB_R,
        SH_LOAD,
        SH_OP_SLL,
        SH_OP_SRL,
        WB_SH,
        EX_I,
        WB_I,
        MEM_ADDR,
        MEM_RD,
        MEM_RD_WAIT,
        MEM_DATA,
        WB_LW,
        MEM_WR,
        BRANCH,
        JUMP,
        EXC_SAVE,
        EXC_RD,
        EXC_WAIT,
        EXC_JMP
    } ctrl_state_e;

    // Wait states hold a memory access open while the wait counter runs.
    function automatic logic is_wait_state(input ctrl_state_e s);
        return (s == FETCH_WAIT) || (s == MEM_RD_WAIT) || (s == EXC_WAIT);
    endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: held at zero while clear is high, then counts up to
// MEM_WAIT-1 and raises done on the last wait cycle.
module ctrl_wait_cnt #(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam int LAST  = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign done = (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!done) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Moore-style multicycle CPU control FSM with decoded datapath enables/selects.
// Define CTRL_EXCEPTION_EN to enable invalid-instruction and overflow traps.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic       IorD,
    output logic [3:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftControl,
    output logic [1:0] PCSource,
    output logic [1:0] ExcpSel
);

`ifdef CTRL_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam bit HAS_WAIT = (MEM_WAIT > 0);

    ctrl_state_e state_q, state_d;
    logic        rst_done_q, rst_done_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic        wait_clear;
    logic        wait_done;

    assign wait_clear = !is_wait_state(state_q);

    ctrl_wait_cnt #(
        .MEM_WAIT(MEM_WAIT)
    ) u_wait_cnt (
        .clk  (clk),
        .rst_n(reset),
        .clear(wait_clear),
        .done (wait_done)
    );

    // Next state; rst_done_q keeps RESET_ST for one full cycle after release.
    always_comb begin
        state_d     = state_q;
        rst_done_d  = 1'b1;
        exc_cause_d = exc_cause_q;
        case (state_q)
            RESET_ST:   if (rst_done_q) state_d = FETCH;
            FETCH:      state_d = HAS_WAIT ? FETCH_WAIT : IR_LOAD;
            FETCH_WAIT: if (wait_done) state_d = IR_LOAD;
            IR_LOAD:    state_d = DECODE;
            DECODE: begin
                state_d = EXC_EN ? EXC_SAVE : FETCH;
                exc_cause_d = EXC_INVALID;
                case (OPCODE)
                    OP_RTYPE: begin
                        case (FUNCT)
                            FN_ADD: state_d = EX_R_ADD;
                            FN_SUB: state_d = EX_R_SUB;
                            FN_AND: state_d = EX_R_AND;
                            FN_SLL: state_d = SH_LOAD;
                            FN_SRL: state_d = SH_LOAD;
                            default: ;
                        endcase
                    end
                    OP_ADDI: state_d = EX_I;
                    OP_LW:   state_d = MEM_ADDR;
                    OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ:  state_d = BRANCH;
                    OP_J:    state_d = JUMP;
                    default: ;
                endcase
            end
            EX_R_ADD, EX_R_SUB: begin
                state_d = WB_R;
                if (EXC_EN && Overflow) begin
                    state_d     = EXC_SAVE;
                    exc_cause_d = EXC_OVERFLOW;
                end
            end
            EX_R_AND:   state_d = WB_R;
            WB_R:       state_d = FETCH;
            SH_LOAD:    state_d = (FUNCT == FN_SRL) ? SH_OP_SRL : SH_OP_SLL;
            SH_OP_SLL:  state_d = WB_SH;
            SH_OP_SRL:  state_d = WB_SH;
            WB_SH:      state_d = FETCH;
            EX_I: begin
                state_d = WB_I;
                if (EXC_EN && Overflow) begin
                    state_d     = EXC_SAVE;
                    exc_cause_d = EXC_OVERFLOW;
                end
            end
            WB_I:        state_d = FETCH;
            MEM_ADDR:    state_d = (OPCODE == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:      state_d = HAS_WAIT ? MEM_RD_WAIT : MEM_DATA;
            MEM_RD_WAIT: if (wait_done) state_d = MEM_DATA;
            MEM_DATA:    state_d = WB_LW;
            WB_LW:       state_d = FETCH;
            MEM_WR:      state_d = FETCH;
            BRANCH:      state_d = FETCH;
            JUMP:        state_d = FETCH;
            EXC_SAVE:    state_d = EXC_RD;
            EXC_RD:      state_d = HAS_WAIT ? EXC_WAIT : EXC_JMP;
            EXC_WAIT:    if (wait_done) state_d = EXC_JMP;
            EXC_JMP:     state_d = FETCH;
            default:     state_d = RESET_ST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_ST;
            rst_done_q  <= 1'b0;
            exc_cause_q <= EXC_INVALID;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= rst_done_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    // Output decode; BRANCH alone also looks at Zero in its own cycle.
    always_comb begin
        PCwrite      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        EPCWrite     = 1'b0;
        MemToReg     = 1'b0;
        RegDest      = 1'b0;
        AluSrcA      = 1'b0;
        IorD         = 1'b0;
        AluSrcB      = SRCB_B;
        ALUControl   = ALU_PASS;
        ShiftControl = SHIFT_HOLD;
        PCSource     = PCSRC_ALU;
        ExcpSel      = EXC_INVALID;
        case (state_q)
            FETCH: begin
                MemRead    = 1'b1;
                AluSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                PCwrite    = 1'b1;
            end
            FETCH_WAIT: MemRead = 1'b1;
            IR_LOAD:    IRWrite = 1'b1;
            DECODE: begin
                AluSrcB    = SRCB_SHL2;
                ALUControl = ALU_ADD;
            end
            EX_R_ADD, EX_R_SUB, EX_R_AND: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_B;
                ALUControl = (state_q == EX_R_ADD) ? ALU_ADD :
                             (state_q == EX_R_SUB) ? ALU_SUB : ALU_AND;
            end
            WB_R: begin
                RegWrite = 1'b1;
                RegDest  = 1'b1;
            end
            SH_LOAD:   ShiftControl = SHIFT_LOAD;
            SH_OP_SLL: ShiftControl = SHIFT_SLL;
            SH_OP_SRL: ShiftControl = SHIFT_SRL;
            WB_SH: begin
                RegWrite = 1'b1;
                RegDest  = 1'b1;
                MemToReg = 1'b1;
            end
            EX_I, MEM_ADDR: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_SEXT;
                ALUControl = ALU_ADD;
            end
            WB_I: RegWrite = 1'b1;
            MEM_RD, MEM_RD_WAIT: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            WB_LW: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            BRANCH: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_B;
                ALUControl = ALU_SUB;
                PCwrite    = Zero;
                PCSource   = Zero ? PCSRC_ALUOUT : PCSRC_ALU;
            end
            JUMP: begin
                PCwrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            EXC_SAVE: begin
                AluSrcB    = SRCB_FOUR;
                ALUControl = ALU_SUB;
                EPCWrite   = EXC_EN;
            end
            EXC_RD, EXC_WAIT: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                ExcpSel = EXC_EN ? exc_cause_q : EXC_INVALID;
            end
            EXC_JMP: begin
                PCwrite  = 1'b1;
                PCSource = PCSRC_EXC;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them. Two instances: MEM_WAIT=1 and 3.
module tb_control_unit;

    typedef struct packed {
        logic       pcw, mw, mr, irw, rw, epc, m2r, rd, asa, iord;
        logic [3:0] srcb;
        logic [2:0] alu;
        logic [2:0] sh;
        logic [1:0] pcs;
        logic [1:0] exc;
    } ctrl_out_t;

    typedef struct {
        string     tag;
        ctrl_out_t exp;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rstA, rstB;
    logic [5:0] opcode, funct;
    logic       zero, ovf;

    logic       aPcWrite, aMemWrite, aMemRead, aIrWrite, aRegWrite, aEpcWrite;
    logic       aMemToReg, aRegDest, aAluSrcA, aIorD;
    logic [3:0] aAluSrcB;
    logic [2:0] aAluControl, aShiftControl;
    logic [1:0] aPcSource, aExcpSel;

    logic       bPcWrite, bMemWrite, bMemRead, bIrWrite, bRegWrite, bEpcWrite;
    logic       bMemToReg, bRegDest, bAluSrcA, bIorD;
    logic [3:0] bAluSrcB;
    logic [2:0] bAluControl, bShiftControl;
    logic [1:0] bPcSource, bExcpSel;

    ctrl_out_t actA, actB;
    sb_item_t  qA[$];
    sb_item_t  qB[$];
    int        totalCnt = 0;
    int        badCnt = 0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(1)) dutA (
        .clk(clk), .reset(rstA), .OPCODE(opcode), .FUNCT(funct),
        .Zero(zero), .Overflow(ovf),
        .PCwrite(aPcWrite), .MemWrite(aMemWrite), .MemRead(aMemRead),
        .IRWrite(aIrWrite), .RegWrite(aRegWrite), .EPCWrite(aEpcWrite),
        .MemToReg(aMemToReg), .RegDest(aRegDest), .AluSrcA(aAluSrcA),
        .IorD(aIorD), .AluSrcB(aAluSrcB), .ALUControl(aAluControl),
        .ShiftControl(aShiftControl), .PCSource(aPcSource), .ExcpSel(aExcpSel)
    );

    control_unit #(.MEM_WAIT(3)) dutB (
        .clk(clk), .reset(rstB), .OPCODE(opcode), .FUNCT(funct),
        .Zero(zero), .Overflow(ovf),
        .PCwrite(bPcWrite), .MemWrite(bMemWrite), .MemRead(bMemRead),
        .IRWrite(bIrWrite), .RegWrite(bRegWrite), .EPCWrite(bEpcWrite),
        .MemToReg(bMemToReg), .RegDest(bRegDest), .AluSrcA(bAluSrcA),
        .IorD(bIorD), .AluSrcB(bAluSrcB), .ALUControl(bAluControl),
        .ShiftControl(bShiftControl), .PCSource(bPcSource), .ExcpSel(bExcpSel)
    );

    assign actA = {aPcWrite, aMemWrite, aMemRead, aIrWrite, aRegWrite, aEpcWrite,
                   aMemToReg, aRegDest, aAluSrcA, aIorD, aAluSrcB, aAluControl,
                   aShiftControl, aPcSource, aExcpSel};
    assign actB = {bPcWrite, bMemWrite, bMemRead, bIrWrite, bRegWrite, bEpcWrite,
                   bMemToReg, bRegDest, bAluSrcA, bIorD, bAluSrcB, bAluControl,
                   bShiftControl, bPcSource, bExcpSel};

    // Expected outputs for each named control step, written from the requirements.
    function automatic ctrl_out_t expOut(input string st);
        ctrl_out_t v;
        v = '0;
        case (st)
            "ZERO":       ;
            "FETCH":      begin v.mr = 1; v.srcb = 4'd1; v.alu = 3'b001; v.pcw = 1; end
            "FETCH_WAIT": v.mr = 1;
            "IR_LOAD":    v.irw = 1;
            "DECODE":     begin v.srcb = 4'd3; v.alu = 3'b001; end
            "EX_ADD":     begin v.asa = 1; v.alu = 3'b001; end
            "EX_SUB":     begin v.asa = 1; v.alu = 3'b010; end
            "EX_AND":     begin v.asa = 1; v.alu = 3'b011; end
            "WB_R":       begin v.rw = 1; v.rd = 1; end
            "SH_LOAD":    v.sh = 3'b001;
            "SH_SLL":     v.sh = 3'b010;
            "SH_SRL":     v.sh = 3'b011;
            "WB_SH":      begin v.rw = 1; v.rd = 1; v.m2r = 1; end
            "EX_I":       begin v.asa = 1; v.srcb = 4'd2; v.alu = 3'b001; end
            "WB_I":       v.rw = 1;
            "MEM_ADDR":   begin v.asa = 1; v.srcb = 4'd2; v.alu = 3'b001; end
            "MEM_RD":     begin v.iord = 1; v.mr = 1; end
            "MEM_DATA":   ;
            "WB_LW":      begin v.rw = 1; v.m2r = 1; end
            "MEM_WR":     begin v.iord = 1; v.mw = 1; end
            "BRANCH_T":   begin v.asa = 1; v.alu = 3'b010; v.pcw = 1; v.pcs = 2'd1; end
            "BRANCH_NT":  begin v.asa = 1; v.alu = 3'b010; end
            "JUMP":       begin v.pcw = 1; v.pcs = 2'd2; end
            "EXC_SAVE":   begin v.srcb = 4'd1; v.alu = 3'b010; v.epc = 1; end
            "EXC_RD_INV": begin v.iord = 1; v.mr = 1; v.exc = 2'd0; end
            "EXC_RD_OVF": begin v.iord = 1; v.mr = 1; v.exc = 2'd1; end
            "EXC_JMP":    begin v.pcw = 1; v.pcs = 2'd3; end
            default:      v = '1;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input ctrl_out_t act, input ctrl_out_t exp);
        totalCnt++;
        if (act !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_item_t it;
        if (qA.size() > 0) begin
            it = qA.pop_front();
            checkOutput({"A:", it.tag}, actA, it.exp);
        end
        if (qB.size() > 0) begin
            it = qB.pop_front();
            checkOutput({"B:", it.tag}, actB, it.exp);
        end
    end

    task automatic pushExp(input int which, input string instr, input string st);
        sb_item_t it;
        it.tag = {instr, "/", st};
        it.exp = expOut(st);
        if (which == 0) qA.push_back(it);
        else qB.push_back(it);
    endtask

    task automatic pushFetch(input int which, input string instr, input int waits);
        pushExp(which, instr, "FETCH");
        for (int i = 0; i < waits; i++) pushExp(which, instr, "FETCH_WAIT");
        pushExp(which, instr, "IR_LOAD");
        pushExp(which, instr, "DECODE");
    endtask

    // Returns one time unit after the rising edge that follows the last checked cycle.
    task automatic waitDrain(input int which);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && qA.size() == 0) || (which == 1 && qB.size() == 0)) return;
        end
        $display("[TB] FAIL drain timeout: queue %0d never emptied", which);
        $fatal(1, "[TB] scoreboard stalled");
    endtask

    task automatic applyStimulus(input int which, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic o);
        waitDrain(which);
        opcode = op;
        funct  = fn;
        zero   = z;
        ovf    = o;
    endtask

    task automatic doReset(input int which);
        waitDrain(which);
        if (which == 0) rstA = 1'b0;
        else rstB = 1'b0;
        pushExp(which, "reset", "ZERO");
        @(negedge clk);
        #2;
        if (which == 0) rstA = 1'b1;
        else rstB = 1'b1;
        @(posedge clk);
        #1;
        pushExp(which, "reset_st", "ZERO");
    endtask

    initial begin
        rstA = 1'b0; rstB = 1'b0;
        opcode = 6'h00; funct = 6'h00; zero = 1'b0; ovf = 1'b0;

        doReset(0);

        applyStimulus(0, 6'h00, 6'h20, 0, 0);
        pushFetch(0, "add", 1); pushExp(0, "add", "EX_ADD"); pushExp(0, "add", "WB_R");

        applyStimulus(0, 6'h00, 6'h22, 0, 0);
        pushFetch(0, "sub", 1); pushExp(0, "sub", "EX_SUB"); pushExp(0, "sub", "WB_R");

        applyStimulus(0, 6'h00, 6'h24, 0, 0);
        pushFetch(0, "and", 1); pushExp(0, "and", "EX_AND"); pushExp(0, "and", "WB_R");

        applyStimulus(0, 6'h00, 6'h00, 0, 0);
        pushFetch(0, "sll", 1); pushExp(0, "sll", "SH_LOAD");
        pushExp(0, "sll", "SH_SLL"); pushExp(0, "sll", "WB_SH");

        applyStimulus(0, 6'h00, 6'h02, 0, 0);
        pushFetch(0, "srl", 1); pushExp(0, "srl", "SH_LOAD");
        pushExp(0, "srl", "SH_SRL"); pushExp(0, "srl", "WB_SH");

        applyStimulus(0, 6'h08, 6'h15, 0, 0);
        pushFetch(0, "addi", 1); pushExp(0, "addi", "EX_I"); pushExp(0, "addi", "WB_I");

        applyStimulus(0, 6'h23, 6'h04, 0, 0);
        pushFetch(0, "lw", 1); pushExp(0, "lw", "MEM_ADDR"); pushExp(0, "lw", "MEM_RD");
        pushExp(0, "lw", "MEM_RD"); pushExp(0, "lw", "MEM_DATA"); pushExp(0, "lw", "WB_LW");

        applyStimulus(0, 6'h2B, 6'h08, 0, 0);
        pushFetch(0, "sw", 1); pushExp(0, "sw", "MEM_ADDR"); pushExp(0, "sw", "MEM_WR");

        applyStimulus(0, 6'h04, 6'h10, 1, 0);
        pushFetch(0, "beq_z1", 1); pushExp(0, "beq_z1", "BRANCH_T");

        applyStimulus(0, 6'h04, 6'h10, 0, 0);
        pushFetch(0, "beq_z0", 1); pushExp(0, "beq_z0", "BRANCH_NT");

        applyStimulus(0, 6'h02, 6'h3C, 0, 0);
        pushFetch(0, "j", 1); pushExp(0, "j", "JUMP");

        applyStimulus(0, 6'h3F, 6'h00, 0, 0);
        pushFetch(0, "badop", 1);
`ifdef CTRL_EXCEPTION_EN
        pushExp(0, "badop", "EXC_SAVE"); pushExp(0, "badop", "EXC_RD_INV");
        pushExp(0, "badop", "EXC_RD_INV"); pushExp(0, "badop", "EXC_JMP");
`endif

        applyStimulus(0, 6'h00, 6'h3F, 0, 0);
        pushFetch(0, "badfn", 1);
`ifdef CTRL_EXCEPTION_EN
        pushExp(0, "badfn", "EXC_SAVE"); pushExp(0, "badfn", "EXC_RD_INV");
        pushExp(0, "badfn", "EXC_RD_INV"); pushExp(0, "badfn", "EXC_JMP");
`endif

        applyStimulus(0, 6'h08, 6'h01, 0, 1);
        pushFetch(0, "addi_ovf", 1); pushExp(0, "addi_ovf", "EX_I");
`ifdef CTRL_EXCEPTION_EN
        pushExp(0, "addi_ovf", "EXC_SAVE"); pushExp(0, "addi_ovf", "EXC_RD_OVF");
        pushExp(0, "addi_ovf", "EXC_RD_OVF"); pushExp(0, "addi_ovf", "EXC_JMP");
`else
        pushExp(0, "addi_ovf", "WB_I");
`endif

        applyStimulus(0, 6'h00, 6'h20, 0, 1);
        pushFetch(0, "add_ovf", 1); pushExp(0, "add_ovf", "EX_ADD");
`ifdef CTRL_EXCEPTION_EN
        pushExp(0, "add_ovf", "EXC_SAVE"); pushExp(0, "add_ovf", "EXC_RD_OVF");
        pushExp(0, "add_ovf", "EXC_RD_OVF"); pushExp(0, "add_ovf", "EXC_JMP");
`else
        pushExp(0, "add_ovf", "WB_R");
`endif

        // sw aborted by reset in its MEM_WR cycle
        applyStimulus(0, 6'h2B, 6'h08, 0, 0);
        pushFetch(0, "sw_rst", 1); pushExp(0, "sw_rst", "MEM_ADDR");
        doReset(0);

        applyStimulus(0, 6'h00, 6'h20, 0, 0);
        pushFetch(0, "add2", 1); pushExp(0, "add2", "EX_ADD"); pushExp(0, "add2", "WB_R");

        applyStimulus(0, 6'h02, 6'h00, 0, 0);
        pushExp(0, "tail", "FETCH");
        waitDrain(0);
        rstA = 1'b0;

        doReset(1);
        applyStimulus(1, 6'h23, 6'h04, 0, 0);
        pushFetch(1, "lw3", 3); pushExp(1, "lw3", "MEM_ADDR");
        for (int i = 0; i < 4; i++) pushExp(1, "lw3", "MEM_RD");
        pushExp(1, "lw3", "MEM_DATA"); pushExp(1, "lw3", "WB_LW");

        applyStimulus(1, 6'h02, 6'h00, 0, 0);
        pushExp(1, "tail3", "FETCH");
        waitDrain(1);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, giving the wait cycles between address presentation and valid Memoria data (legal 0..3).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  reset; asynchronous, active-low.
REQ-004 OPCODE  in  6  instruction register bits 31:26.
REQ-005 FUNCT  in  6  OFFSET bits 5:0.
REQ-006 Zero, Overflow  in  1 each  ALU flags, sampled in the state that uses them.
REQ-007 PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite  out  1 each  datapath register and memory enables.
REQ-008 MemToReg, RegDest, AluSrcA, IorD  out  1 each  mux selects.
REQ-009 AluSrcB  out  4  operand-B select: 0 B, 1 const 4, 2 SignExt, 3 ShiftL2.
REQ-010 ALUControl  out  3  Ula32 op: 000 pass A, 001 add, 010 sub, 011 and.
REQ-011 ShiftControl  out  3  RegDesloc op: 000 hold, 001 load, 010 sll, 011 srl.
REQ-012 PCSource  out  2  0 ALUResult, 1 ALUout, 2 jump target, 3 exception vector.
REQ-013 ExcpSel  out  2  exception vector select: 0 invalid opcode, 1 overflow.

Function
REQ-014 SHALL be a Moore FSM; every output is a decode of the registered state only, and any output not listed for a state is 0.
REQ-015 FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1 for one cycle, then MEM_WAIT cycles in FETCH_WAIT, then IR_LOAD with IRWrite=1.
REQ-016 DECODE: AluSrcB=3, ALUControl=001 (branch target into ALUout), then dispatch on OPCODE.
REQ-017 OPCODE 0x00 with FUNCT add(0x20)/sub(0x22)/and(0x24): EX_R (AluSrcA=1, AluSrcB=0, matching ALUControl), then WB_R (RegWrite=1, RegDest=1, MemToReg=0).
REQ-018 OPCODE 0x00 with FUNCT sll(0x00)/srl(0x02): SH_LOAD (ShiftControl=001), SH_OP (010 or 011), then WB_R with MemToReg selecting the shifter.
REQ-019 addi (0x08): EX_I (AluSrcA=1, AluSrcB=2, add), then WB_I (RegWrite=1, RegDest=0).
REQ-020 lw (0x23)/sw (0x2B): MEM_ADDR (address into ALUout); lw: MEM_RD (IorD=1, MemRead=1) + MEM_WAIT wait cycles, then WB_LW (RegWrite=1, MemToReg=1); sw: MEM_WR (IorD=1, MemWrite=1) for exactly one cycle.
REQ-021 beq (0x04): BRANCH (sub); PCwrite=1, PCSource=1 only when Zero=1 in that cycle.
REQ-022 j (0x02): JUMP, PCwrite=1, PCSource=2.
REQ-023 Every instruction's last state SHALL return to FETCH; latency with MEM_WAIT=1: R/addi 6 cycles, lw 9, sw 6, beq/j 5.
REQ-024 Unknown OPCODE, or unknown FUNCT under 0x00, SHALL follow the REQ-031 path.
REQ-025 Wait counter SHALL be MEM_WAIT-wide-sufficient, cleared on entry to each wait state; MEM_WAIT=0 skips wait states entirely.

Reset
REQ-026 reset=0 SHALL force state RESET_ST and clear the wait counter immediately, regardless of clk, aborting any instruction in flight.
REQ-027 During reset and in RESET_ST all outputs SHALL be 0; first cycle after release is RESET_ST, next is FETCH.
REQ-028 A sw interrupted by reset SHALL never produce MemWrite=1 after reset asserts.

Configuration
REQ-029 Macro CTRL_EXCEPTION_EN SHALL compile exception handling in or out.
REQ-030 Defined: Overflow=1 sampled in EX_R (add/sub) or EX_I SHALL suppress write-back.
REQ-031 Defined: invalid or overflow path = EXC_SAVE (AluSrcB=1, sub, EPCWrite=1 saving PC-4), EXC_RD (IorD=1, MemRead=1, ExcpSel set) + MEM_WAIT waits, EXC_JMP (PCwrite=1, PCSource=3), then FETCH.
REQ-032 Undefined: Overflow ignored, invalid instructions go DECODE to FETCH as a NOP, EPCWrite and ExcpSel tied 0.

Structure
REQ-033 Opcode, FUNCT, ALUControl, ShiftControl, AluSrcB and PCSource encodings and the state enumeration SHALL live in shared package cpu_ctrl_pkg.
REQ-034 One sub-module, ctrl_wait_cnt (the MEM_WAIT counter with clear and done), is natural; FSM and output decode stay in control_unit.

Verification
REQ-035 add r3,r1,r2 (OPCODE 0, FUNCT 0x20), MEM_WAIT=1 -> IRWrite at cycle 3, RegWrite=1 RegDest=1 at cycle 6, back in FETCH cycle 7.
REQ-036 beq with Zero=1 then Zero=0 -> PCwrite=1 PCSource=1 only in the first case; PCwrite 0 in BRANCH otherwise.
REQ-037 lw with MEM_WAIT=3 -> MemRead high 4 cycles in MEM_RD span, MemToReg=1 RegWrite=1 in cycle 13.
REQ-038 reset driven 0 mid-MEM_WR -> all outputs 0 asynchronously, FETCH 2 cycles after release.
REQ-039 With CTRL_EXCEPTION_EN: OPCODE 0x3F -> EPCWrite=1, then ExcpSel=0 MemRead=1, then PCwrite=1 PCSource=3; addi with Overflow=1 -> no RegWrite, ExcpSel=1.
REQ-040 Without CTRL_EXCEPTION_EN: OPCODE 0x3F -> DECODE then FETCH, EPCWrite never 1.
